// File: rtl/rcpu_pkg.sv
// rcpu_pkg: shared encodings for the RCPU control path.
//   - ALU operation codes driven on alu_op
//   - mc_ctrl state encodings (also visible on the debug state port)
//   - opcode / funct field constants for the supported instructions
//   - alu_src_b and pc_src select encodings
package rcpu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BOFS = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALU-operation decode for R-type and
// immediate ALU instructions.
//   opcode, funct : instruction fields IR[31:26], IR[5:0]
//   alu_op        : ALU operation code (ADD when not an ALU instruction)
//   ext_zero      : immediate is zero-extended (andi/ori/xori)
//   ovf_chk       : signed overflow suppresses writeback (add/sub/addi)
//   legal         : opcode/funct pair is a supported ALU instruction
module alu_op_decode
  import rcpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       ext_zero,
  output logic       ovf_chk,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_ADD;
    ext_zero = 1'b0;
    ovf_chk  = 1'b0;
    legal    = 1'b1;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
        FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLTU: alu_op = ALU_SLTU;
        FN_SLLV: alu_op = ALU_SLL;
        default: legal  = 1'b0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI:  begin alu_op = ALU_ADD; ovf_chk  = 1'b1; end
        OP_SLTIU: alu_op = ALU_SLTU;
        OP_ANDI:  begin alu_op = ALU_AND; ext_zero = 1'b1; end
        OP_ORI:   begin alu_op = ALU_OR;  ext_zero = 1'b1; end
        OP_XORI:  begin alu_op = ALU_XOR; ext_zero = 1'b1; end
        default:  legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle Moore control unit for the RCPU datapath.
//   clk, rst_n      : clock, asynchronous active-low reset
//   opcode, funct   : instruction fields (stable from DECODE to next FETCH)
//   zf, of          : combinational ALU zero / signed-overflow flags
//   alu_op          : ALU operation code
//   alu_src_a/b     : ALU operand selects; ext_zero: immediate extension
//   i_or_d          : memory address select (PC / ALUOut)
//   mem_read/write  : memory strobes; ir_write: load IR
//   pc_we, pc_src   : PC write enable (zf-qualified in BRANCH), PC source
//   reg_write, reg_dst, mem_to_reg : register-file writeback controls
//   ovf_trap        : pulse when an overflowing writeback is suppressed
//   illegal         : high while halted on an unsupported instruction
//   retired         : completed-instruction count, wraps at 2^CNT_W
//   state           : current state code (debug)
module mc_ctrl
  import rcpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zf,
  input  logic             of,
  output logic [2:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             ovf_trap,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_e           state_q, state_d;
  logic             run_q;
  logic             ovf_q;
  logic [CNT_W-1:0] retired_q;

  logic [2:0] dec_alu_op;
  logic       dec_ext_zero;
  logic       dec_ovf_chk;
  logic       dec_legal;

  alu_op_decode u_alu_op_decode (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_alu_op),
    .ext_zero (dec_ext_zero),
    .ovf_chk  (dec_ovf_chk),
    .legal    (dec_legal)
  );

  // run_q holds the FSM in IDLE for one extra edge after reset release,
  // so FETCH is entered on the second rising edge after deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      ovf_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      // Overflow is only meaningful for the cycle right after EXEC/EXEC_I.
      if (state_q == S_EXEC || state_q == S_EXEC_I)
        ovf_q <= of & dec_ovf_chk;
      else
        ovf_q <= 1'b0;
      if (state_q == S_ALU_WB || state_q == S_MEM_WB || state_q == S_MEM_WR ||
          state_q == S_BRANCH || state_q == S_JUMP)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    ext_zero   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ovf_trap   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_we     = 1'b1;
        pc_src    = PC_SRC_ALU;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes PC + (sext(imm) << 2) for a possible branch.
        alu_src_b = SRC_B_BOFS;
        case (opcode)
          OP_RTYPE:                                    state_d = S_EXEC;
          OP_LW, OP_SW:                                state_d = S_MEM_ADDR;
          OP_BEQ:                                      state_d = S_BRANCH;
          OP_J:                                        state_d = S_JUMP;
          OP_ADDI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
          default:                                     state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        alu_op    = dec_alu_op;
        state_d   = dec_legal ? S_ALU_WB : S_HALT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = dec_alu_op;
        ext_zero  = dec_ext_zero;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = ~ovf_q;
        reg_dst   = (opcode == OP_RTYPE);
        ovf_trap  = ovf_q;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_we     = zf;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        pc_src  = PC_SRC_JUMP;
        state_d = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zf = 1'b0;
  logic             of = 1'b0;
  logic [2:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             ext_zero;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             ovf_trap;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  int nvec = 0;
  int nerr = 0;
  int ret_exp = 0;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zf         (zf),
    .of         (of),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ovf_trap   (ovf_trap),
    .illegal    (illegal),
    .retired    (retired),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] ctl_now();
    return {alu_op, alu_src_a, alu_src_b, ext_zero, i_or_d, mem_read, mem_write,
            ir_write, pc_we, pc_src, reg_write, reg_dst, mem_to_reg, ovf_trap, illegal};
  endfunction

  // Expected control word for a state, straight from the per-state table.
  function automatic logic [18:0] exp_ctl(input int st, input logic [2:0] aop, input logic ez,
                                          input logic ovfq, input logic zf_v, input logic rt);
    logic [2:0] e_op = 3'b100;
    logic e_sa = 0, e_ez = 0, e_iod = 0, e_mr = 0, e_mw = 0, e_ir = 0, e_pw = 0;
    logic e_rw = 0, e_rd = 0, e_m2r = 0, e_trap = 0, e_ill = 0;
    logic [1:0] e_sb = 2'b00, e_ps = 2'b00;
    case (st)
      1:  begin e_mr = 1; e_ir = 1; e_sb = 2'b01; e_pw = 1; end
      2:  e_sb = 2'b11;
      3:  begin e_sa = 1; e_op = aop; end
      4:  begin e_sa = 1; e_sb = 2'b10; e_op = aop; e_ez = ez; end
      5:  begin e_rw = ~ovfq; e_rd = rt; e_trap = ovfq; end
      6:  begin e_sa = 1; e_sb = 2'b10; end
      7:  begin e_mr = 1; e_iod = 1; end
      8:  begin e_rw = 1; e_m2r = 1; end
      9:  begin e_mw = 1; e_iod = 1; end
      10: begin e_sa = 1; e_op = 3'b101; e_ps = 2'b01; e_pw = zf_v; end
      11: begin e_pw = 1; e_ps = 2'b10; end
      12: e_ill = 1;
      default: ;
    endcase
    return {e_op, e_sa, e_sb, e_ez, e_iod, e_mr, e_mw, e_ir, e_pw, e_ps,
            e_rw, e_rd, e_m2r, e_trap, e_ill};
  endfunction

  // Async reset assert, check, then release; leaves the bench #1 after the
  // edge that enters FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_mem_read", mem_read, 0);
    @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_retired", retired, 0);
    check_eq("rst_ctl", ctl_now(), exp_ctl(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_idle0", state, 0);
    @(posedge clk); #1;
    check_eq("rel_idle1", state, 0);
    @(posedge clk); #1;
    ret_exp = 0;
  endtask

  // Instruction-level reference: the state sequence and expected strobes
  // follow from opcode/funct; retired advances once per completed instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic of_v, input logic zf_v);
    int seq[$];
    logic [2:0] aop = 3'b100;
    logic ez = 0, ovf = 0, rt = 0;
    opcode = op; funct = fn; of = of_v; zf = zf_v;
    case (op)
      6'h00: begin
        rt = 1;
        case (fn)
          6'h20: begin aop = 3'b100; ovf = of_v; end
          6'h22: begin aop = 3'b101; ovf = of_v; end
          6'h24: aop = 3'b000;
          6'h25: aop = 3'b001;
          6'h26: aop = 3'b010;
          6'h27: aop = 3'b011;
          6'h2B: aop = 3'b110;
          6'h04: aop = 3'b111;
          default: aop = 3'b100;
        endcase
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04})
          seq = '{1, 2, 3, 5};
        else
          seq = '{1, 2, 3, 12};
      end
      6'h08: begin aop = 3'b100; ovf = of_v; seq = '{1, 2, 4, 5}; end
      6'h0B: begin aop = 3'b110; seq = '{1, 2, 4, 5}; end
      6'h0C: begin aop = 3'b000; ez = 1; seq = '{1, 2, 4, 5}; end
      6'h0D: begin aop = 3'b001; ez = 1; seq = '{1, 2, 4, 5}; end
      6'h0E: begin aop = 3'b010; ez = 1; seq = '{1, 2, 4, 5}; end
      6'h23: seq = '{1, 2, 6, 7, 8};
      6'h2B: seq = '{1, 2, 6, 9};
      6'h04: seq = '{1, 2, 10};
      6'h02: seq = '{1, 2, 11};
      default: seq = '{1, 2, 12};
    endcase
    foreach (seq[i]) begin
      @(negedge clk);
      check_eq($sformatf("op%0h_fn%0h_state_c%0d", op, fn, i), state, seq[i]);
      check_eq($sformatf("op%0h_fn%0h_ctl_st%0d", op, fn, seq[i]), ctl_now(),
               exp_ctl(seq[i], aop, ez, ovf, zf_v, rt));
      if (i == 0) check_eq($sformatf("op%0h_retired", op), retired, ret_exp);
      @(posedge clk); #1;
    end
    if (seq[seq.size()-1] != 12) ret_exp = (ret_exp + 1) % (1 << CNT_W);
  endtask

  logic [5:0] r_fn[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04};
  logic [5:0] i_op[5] = '{6'h08, 6'h0B, 6'h0C, 6'h0D, 6'h0E};

  initial begin
    #3;
    do_reset();

    run_instr(6'h00, 6'h20, 1'b0, 1'b0);   // add, no overflow
    run_instr(6'h00, 6'h22, 1'b1, 1'b0);   // sub, overflow trap
    run_instr(6'h23, 6'h00, 1'b0, 1'b0);   // lw
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0);   // sw
    run_instr(6'h04, 6'h00, 1'b0, 1'b1);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 1'b0);   // beq not taken
    run_instr(6'h0D, 6'h00, 1'b1, 1'b0);   // ori, of ignored
    run_instr(6'h08, 6'h00, 1'b1, 1'b0);   // addi overflow
    run_instr(6'h02, 6'h00, 1'b0, 1'b0);   // j

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      int k = $urandom_range(0, 5);
      fn = 6'($urandom);
      case (k)
        0: begin op = 6'h00; fn = r_fn[$urandom_range(0, 7)]; end
        1: op = i_op[$urandom_range(0, 4)];
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        default: op = 6'h02;
      endcase
      run_instr(op, fn, 1'($urandom), 1'($urandom));
    end

    // Illegal opcode: HALT held, retired frozen.
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_eq("halt_state", state, 12);
      check_eq("halt_illegal", illegal, 1);
      check_eq("halt_retired", retired, ret_exp);
      opcode = 6'($urandom);
    end

    // Illegal funct halts from EXEC.
    #2;
    do_reset();
    run_instr(6'h00, 6'h3F, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("halt_fn_state", state, 12);

    // Reset in the middle of MEM_RD.
    #2;
    do_reset();
    opcode = 6'h23; funct = 6'h00; of = 0; zf = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("memrd_state", state, 7);
    check_eq("memrd_mem_read", mem_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_state", state, 0);
    check_eq("midrst_mem_read", mem_read, 0);
    check_eq("midrst_ctl", ctl_now(), exp_ctl(0, 0, 0, 0, 0, 0));
    check_eq("midrst_retired", retired, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
